warp_inst_buffer: RTL
=====================

# warp_inst_buffer

Per-warp instruction buffer that sits directly downstream of the fetch stage. It accepts up to two fetched packets per cycle for one warp and queues them in a per-warp FIFO. Each cycle it picks one ready, non-empty warp round-robin and issues that warp's oldest packet to decode. It returns the selected warp and entry, which fetch uses to track free slots, and a per-warp almost-full vector that throttles fetch.

## Interface
- NUM_WARP, 4, warps per SM
- NUM_WARP_LOG, 2, log2(NUM_WARP)
- NUM_ENTRY, 4, FIFO depth per warp; power of two, at least 2
- NUM_ENTRY_LOG, 2, log2(NUM_ENTRY)
- SIZE_PC, 32, PC width
- SIZE_INSTRUCTION, 64, instruction width; packet width P = SIZE_INSTRUCTION+SIZE_PC, with {instruction, PC}, PC in the LSBs

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- stall_i  in  1  downstream stall; freezes issue
- instWarp_i  in  NUM_WARP_LOG  warp of the incoming packets
- instPacket0Valid_i  in  1  packet0 valid
- instPacket0_i  in  P  older packet
- instPacket1Valid_i  in  1  packet1 valid; honoured only when packet0 is also valid
- instPacket1_i  in  P  younger packet
- flush_i  in  1  flush one warp (exit or reconvergence)
- flushWarp_i  in  NUM_WARP_LOG  warp to flush
- warpReady_i  in  NUM_WARP  per-warp scoreboard ready
- selectedPacketValid_o  out  1  issue valid (registered)
- selectedWarp_o  out  NUM_WARP_LOG  issued warp
- selectedEntry_o  out  NUM_ENTRY_LOG  FIFO slot that was issued
- selectedPacket_o  out  P  issued packet
- warpAlmostFull_o  out  NUM_WARP  bit w = 1 when warp w has fewer than 2 free slots (combinational from state)
- overflow_o  out  1  sticky error: a write was dropped

## Operation
- Each warp has its own state: head pointer, tail pointer (each NUM_ENTRY_LOG bits, wrapping modulo NUM_ENTRY) and a count of NUM_ENTRY_LOG+1 bits.
- Write of n packets (n = 0, 1 or 2):
  - packet0 goes to slot tail; packet1 goes to slot tail+1 (mod NUM_ENTRY).
  - tail advances by n; count increases by n.
- Write rejection: if count − pop + n > NUM_ENTRY, the whole write is dropped and overflow_o is set. overflow_o clears only on reset.
- Packet1 valid while packet0 is invalid is ignored.
- Issue eligibility: warp w is eligible when count > 0, warpReady_i[w] = 1 and w is not being flushed this cycle.
- Round-robin selection:
  - The arbiter searches from rrPtr+1, wrapping modulo NUM_WARP.
  - On a grant, rrPtr takes the granted warp.
  - rrPtr resets to NUM_WARP−1, so warp 0 wins first.
- Pop: on a grant with stall_i = 0, the head slot is registered to the outputs, head advances by 1 and count decreases by 1.
- Simultaneous write and pop on the same warp: count ← count + n − 1; reads use the pre-write contents.
- Flush:
  - Head, tail and count of flushWarp_i are zeroed.
  - A same-cycle write to that warp is dropped without setting overflow_o.
  - Writes and issue for other warps proceed normally.
- There is no bypass: a packet written in cycle t can be selected at t+1 at the earliest and appears on the outputs at t+2.

## Timing
- Reset values:
  - all outputs 0, except warpAlmostFull_o, which is 0 for NUM_ENTRY at least 2
  - all counts and pointers 0; rrPtr = NUM_WARP−1
- Issue latency: select in cycle t, outputs valid from t+1.
- stall_i = 1:
  - The output registers hold their values, including valid.
  - No pop occurs and rrPtr does not move.
  - Writes and flushes continue.
- No eligible warp and stall_i = 0: selectedPacketValid_o ← 0 at the next edge; the other outputs hold.
- Asserting reset mid-operation clears everything immediately, asynchronously. Reset release is synchronised externally.

## Configuration
- IBUF_STALL_CNT_EN:
  - When defined: adds output port issueBubbleCnt_o (32-bit). It increments each cycle in which some warp has count > 0, stall_i = 0 and nothing is granted. It saturates at 2^32−1 and resets to 0.
  - When undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package gpu_pipe_pkg holds:
  - the SIZE_*, NUM_WARP* and NUM_ENTRY* constants
  - the inst_packet_t typedef {instruction, pc}
- One sub-module: warp_rr_arbiter (NUM_WARP request bits plus rrPtr in, one-hot grant and its index out; combinational). The rrPtr register stays in the parent.

## Test plan
- Reset, then a 2-packet write to warp 0 (PCs 0x10, 0x11), warpReady_i = 4'b1111 → issue warp 0 entry 0 with PC 0x10, then entry 1 with PC 0x11; outputs valid 2 and 3 cycles after the write.
- Warps 0–3 each hold 2 packets, all ready → issue order is warps 0,1,2,3,0,1,2,3; no warp is issued twice in a row.
- Fill warp 1 to 4 entries → warpAlmostFull_o[1] = 1. A further 1-packet write with no pop is dropped and overflow_o = 1; the contents are unchanged.
- Hold stall_i = 1 for 3 cycles with valid output PC 0x20 → the outputs hold 0x20 and the counts are unchanged. After release, the next packet issues.
- Warp 2 has 3 entries; assert flush_i with flushWarp_i = 2 together with a write to warp 2 → warp 2 count = 0, no issue from warp 2, overflow_o = 0.
- Head at slot 3 of warp 0 with a 2-packet write → the packets land in slots 3 and 0; later issues report selectedEntry_o = 3, then 0.

Source files
------------

// File: rtl/gpu_pipe_pkg.sv
// Shared GPU front-end constants and the fetched-packet layout {instruction, pc}.
package gpu_pipe_pkg;

    localparam int NUM_WARP         = 4;
    localparam int NUM_WARP_LOG     = 2;
    localparam int NUM_ENTRY        = 4;
    localparam int NUM_ENTRY_LOG    = 2;
    localparam int SIZE_PC          = 32;
    localparam int SIZE_INSTRUCTION = 64;
    localparam int SIZE_PACKET      = SIZE_INSTRUCTION + SIZE_PC;

    typedef struct packed {
        logic [SIZE_INSTRUCTION-1:0] instruction;
        logic [SIZE_PC-1:0]          pc;
    } inst_packet_t;

endpackage

// File: rtl/warp_rr_arbiter.sv
// Combinational round-robin pick over warp requests, searching upward from rrPtr+1.
module warp_rr_arbiter
    import gpu_pipe_pkg::*;
(
    input  logic [NUM_WARP-1:0]     request,
    input  logic [NUM_WARP_LOG-1:0] rrPtr,
    output logic [NUM_WARP-1:0]     grant,
    output logic [NUM_WARP_LOG-1:0] grantIdx,
    output logic                    grantValid
);

    logic [NUM_WARP_LOG-1:0] cand;

    always_comb begin
        grant      = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_WARP; i++) begin
            cand = NUM_WARP_LOG'((int'(rrPtr) + i) % NUM_WARP);
            if (!grantValid && request[cand]) begin
                grantValid = 1'b1;
                grantIdx   = cand;
            end
        end
        grant[grantIdx] = grantValid;
    end

endmodule

// File: rtl/warp_inst_buffer.sv
// Per-warp instruction FIFOs between fetch and decode with round-robin issue.
// Optional IBUF_STALL_CNT_EN adds issueBubbleCnt_o (saturating idle-issue counter).
module warp_inst_buffer
    import gpu_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_i,
    input  logic [NUM_WARP_LOG-1:0]  instWarp_i,
    input  logic                     instPacket0Valid_i,
    input  logic [SIZE_PACKET-1:0]   instPacket0_i,
    input  logic                     instPacket1Valid_i,
    input  logic [SIZE_PACKET-1:0]   instPacket1_i,
    input  logic                     flush_i,
    input  logic [NUM_WARP_LOG-1:0]  flushWarp_i,
    input  logic [NUM_WARP-1:0]      warpReady_i,
    output logic                     selectedPacketValid_o,
    output logic [NUM_WARP_LOG-1:0]  selectedWarp_o,
    output logic [NUM_ENTRY_LOG-1:0] selectedEntry_o,
    output logic [SIZE_PACKET-1:0]   selectedPacket_o,
    output logic [NUM_WARP-1:0]      warpAlmostFull_o,
`ifdef IBUF_STALL_CNT_EN
    output logic                     overflow_o,
    output logic [31:0]              issueBubbleCnt_o
`else
    output logic                     overflow_o
`endif
);

    localparam int CNT_W = NUM_ENTRY_LOG + 1;
    localparam int LVL_W = NUM_ENTRY_LOG + 2;

    logic [NUM_ENTRY_LOG-1:0] headAll  [NUM_WARP];
    logic [CNT_W-1:0]         countAll [NUM_WARP];
    inst_packet_t             headPkt  [NUM_WARP];

    logic [NUM_WARP-1:0]     request;
    logic [NUM_WARP-1:0]     grant;
    logic [NUM_WARP_LOG-1:0] grantIdx;
    logic                    grantValid;
    logic [NUM_WARP_LOG-1:0] rrPtr;

    logic [1:0]       wrCount;
    logic             wrFlushed;
    logic             popSameWarp;
    logic [LVL_W-1:0] wrLevel;
    logic             wrDrop;
    logic             wrAccept;

    assign wrCount     = instPacket0Valid_i ? (instPacket1Valid_i ? 2'd2 : 2'd1) : 2'd0;
    assign wrFlushed   = flush_i && (flushWarp_i == instWarp_i);
    assign popSameWarp = !stall_i && grant[instWarp_i];
    // Occupancy the target warp would reach this cycle, counting a same-cycle pop.
    assign wrLevel     = LVL_W'(countAll[instWarp_i]) - LVL_W'(popSameWarp) + LVL_W'(wrCount);
    assign wrDrop      = (wrCount != 2'd0) && !wrFlushed && (wrLevel > LVL_W'(NUM_ENTRY));
    assign wrAccept    = (wrCount != 2'd0) && !wrFlushed && !wrDrop;

    for (genvar w = 0; w < NUM_WARP; w++) begin : gWarp
        localparam logic [NUM_WARP_LOG-1:0] WID = NUM_WARP_LOG'(w);

        logic [NUM_ENTRY_LOG-1:0] head;
        logic [NUM_ENTRY_LOG-1:0] tail;
        logic [CNT_W-1:0]         count;
        inst_packet_t             mem [NUM_ENTRY];
        logic                     flushHere;
        logic                     popHere;
        logic                     wrHere;

        assign flushHere = flush_i && (flushWarp_i == WID);
        assign popHere   = !stall_i && grant[w];
        assign wrHere    = wrAccept && (instWarp_i == WID);

        assign request[w]          = (count != '0) && warpReady_i[w] && !flushHere;
        assign warpAlmostFull_o[w] = count > CNT_W'(NUM_ENTRY - 2);
        assign headAll[w]          = head;
        assign countAll[w]         = count;
        assign headPkt[w]          = mem[head];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (flushHere) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (popHere) head <= head + NUM_ENTRY_LOG'(1);
                if (wrHere)  tail <= tail + NUM_ENTRY_LOG'(wrCount);
                count <= count + (wrHere ? CNT_W'(wrCount) : CNT_W'(0)) - CNT_W'(popHere);
            end
        end

        always_ff @(posedge clk) begin
            if (wrHere) begin
                mem[tail] <= instPacket0_i;
                if (wrCount == 2'd2) mem[tail + NUM_ENTRY_LOG'(1)] <= instPacket1_i;
            end
        end
    end

    warp_rr_arbiter uArb (
        .request    (request),
        .rrPtr      (rrPtr),
        .grant      (grant),
        .grantIdx   (grantIdx),
        .grantValid (grantValid)
    );

    // Issue stage boundary: outputs freeze entirely while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            selectedPacketValid_o <= 1'b0;
            selectedWarp_o        <= '0;
            selectedEntry_o       <= '0;
            selectedPacket_o      <= '0;
            rrPtr                 <= NUM_WARP_LOG'(NUM_WARP - 1);
            overflow_o            <= 1'b0;
        end else begin
            if (!stall_i) begin
                selectedPacketValid_o <= grantValid;
                if (grantValid) begin
                    selectedWarp_o   <= grantIdx;
                    selectedEntry_o  <= headAll[grantIdx];
                    selectedPacket_o <= headPkt[grantIdx];
                    rrPtr            <= grantIdx;
                end
            end
            if (wrDrop) overflow_o <= 1'b1;
        end
    end

`ifdef IBUF_STALL_CNT_EN
    logic anyPending;

    always_comb begin
        anyPending = 1'b0;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (countAll[w] != '0) anyPending = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issueBubbleCnt_o <= '0;
        end else if (anyPending && !stall_i && !grantValid && (issueBubbleCnt_o != '1)) begin
            issueBubbleCnt_o <= issueBubbleCnt_o + 32'd1;
        end
    end
`endif

endmodule
